// File: rtl/addsub_arb_pkg.sv
// -----------------------------------------------------------------------------
// addsub_arb_pkg
//   Shared types and constants for the add/sub sharing arbiter.
//   - state_t   : scheduler FSM encoding (IDLE -> EXEC -> RESP -> IDLE)
//   - OP_ADD/SUB: request opcode values carried on req_op
//   - ovf_calc  : two's-complement overflow from operand/result sign bits.
//                 It is used only when ADDSUB_ARB_OVF_EN is defined.
// -----------------------------------------------------------------------------
package addsub_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Signed overflow from the sign bits.
   // Add overflows when both operands share a sign and the sum's sign differs.
   // Sub overflows when the operand signs differ and the result's sign differs
   // from A.
   function automatic logic ovf_calc(input logic a_msb,
                                     input logic b_msb,
                                     input logic s_msb,
                                     input logic op);
      logic same_sign;
      same_sign = (a_msb == b_msb);
      if (op == OP_ADD)
         ovf_calc = same_sign && (s_msb != a_msb);
      else
         ovf_calc = !same_sign && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. It searches req_i starting at
//   index ptr_i and moves upward, wrapping at NREQ. The first set bit wins.
//   Ports:
//     req_i  [NREQ]  request vector
//     ptr_i  [IW]    index with highest priority this cycle
//     gnt_o  [NREQ]  one-hot grant; zero when no request is set
//     idx_o  [IW]    binary index of the grant; zero when none
//     any_o          at least one request is present
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   int unsigned k;
   logic [IW-1:0] kk;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = 0;
      kk    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = 32'(ptr_i) + i;
         if (k >= NREQ) k = k - NREQ;
         kk = IW'(k);
         if (!any_o && req_i[kk]) begin
            any_o     = 1'b1;
            gnt_o[kk] = 1'b1;
            idx_o     = kk;
         end
      end
   end

endmodule

// File: rtl/addsub_share_arb.sv
// -----------------------------------------------------------------------------
// addsub_share_arb
//   Round-robin scheduler that shares one combinational ripple add/sub unit
//   among NREQ requesters. It accepts one operation at a time in IDLE. It then
//   drives the adder for SETTLE_CYC cycles, captures S/Cout, and presents the
//   result with the requester ID on a single valid/ready response channel.
//
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     req_valid/req_ready    per-requester handshake; ready is one-hot, IDLE only
//     req_a/req_b/req_op     per-requester operands (slice i = requester i), op 1=sub
//     rsp_valid/rsp_ready    result handshake
//     rsp_id/rsp_sum/rsp_cout result: requester index, S, raw Cout
//     add_a/add_b/add_cin/add_sop  drive to the shared adder
//     add_s/add_cout         return from the shared adder
//
//   Optional feature: when ADDSUB_ARB_OVF_EN is defined, the rsp_ovf output
//   carries the signed overflow of the operation. It is captured with rsp_sum.
// -----------------------------------------------------------------------------
module addsub_share_arb
   import addsub_arb_pkg::*;
#(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned W          = 4,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*W-1:0]        req_a,
   input  logic [NREQ*W-1:0]        req_b,
   input  logic [NREQ-1:0]          req_op,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [W-1:0]             rsp_sum,
   output logic                     rsp_cout,
`ifdef ADDSUB_ARB_OVF_EN
   output logic                     rsp_ovf,
`endif
   output logic [W-1:0]             add_a,
   output logic [W-1:0]             add_b,
   output logic                     add_cin,
   output logic                     add_sop,
   input  logic [W-1:0]             add_s,
   input  logic                     add_cout
);

   localparam int unsigned IW       = $clog2(NREQ);
   localparam logic [3:0]  CNT_LAST = 4'(SETTLE_CYC - 1);

   state_t          state_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   id_q;
   logic [3:0]      cnt_q;

   logic            rsp_valid_q;
   logic [IW-1:0]   rsp_id_q;
   logic [W-1:0]    rsp_sum_q;
   logic            rsp_cout_q;
`ifdef ADDSUB_ARB_OVF_EN
   logic            rsp_ovf_q;
`endif

   // The adder drive registers also serve as the latched operands. They hold
   // A/B/op for the whole EXEC phase and are cleared on the transition to RESP.
   logic [W-1:0]    add_a_q;
   logic [W-1:0]    add_b_q;
   logic            add_op_q;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic            sel_op;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // Operand mux driven by the one-hot grant
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_a = sel_a | req_a[i*W +: W];
            sel_b = sel_b | req_b[i*W +: W];
         end
      end
      sel_op = |(req_op & gnt);
   end

   assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
         rsp_ovf_q   <= 1'b0;
`endif
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_op_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_any) begin
                  add_a_q  <= sel_a;
                  add_b_q  <= sel_b;
                  add_op_q <= (sel_op == OP_SUB);
                  id_q     <= gnt_idx;
                  rr_ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                  cnt_q    <= '0;
                  state_q  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q == CNT_LAST) begin
                  rsp_sum_q   <= add_s;
                  rsp_cout_q  <= add_cout;
                  rsp_id_q    <= id_q;
`ifdef ADDSUB_ARB_OVF_EN
                  rsp_ovf_q   <= ovf_calc(add_a_q[W-1], add_b_q[W-1],
                                          add_s[W-1], add_op_q);
`endif
                  rsp_valid_q <= 1'b1;
                  add_a_q     <= '0;
                  add_b_q     <= '0;
                  add_op_q    <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
`ifdef ADDSUB_ARB_OVF_EN
   assign rsp_ovf   = rsp_ovf_q;
`endif
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_op_q;
   assign add_sop   = add_op_q;

endmodule

// File: tb/tb_addsub_share_arb.sv
module tb_addsub_share_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic [1:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [0:0]  rsp_id;
   logic [3:0]  rsp_sum;
   logic        rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
   logic        rsp_ovf;
`endif
   logic [3:0]  add_a;
   logic [3:0]  add_b;
   logic        add_cin;
   logic        add_sop;
   logic [3:0]  add_s;
   logic        add_cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   addsub_share_arb #(
      .NREQ       (2),
      .W          (4),
      .SETTLE_CYC (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
`ifdef ADDSUB_ARB_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sop   (add_sop),
      .add_s     (add_s),
      .add_cout  (add_cout)
   );

   // Shared ripple add/sub unit: B is inverted by s_op, carry-in from Cin
   logic c;
   logic bb;
   always_comb begin
      add_s = '0;
      c     = add_cin;
      bb    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bb       = add_b[i] ^ add_sop;
         add_s[i] = add_a[i] ^ bb ^ c;
         c        = (add_a[i] & bb) | (c & (add_a[i] ^ bb));
      end
      add_cout = c;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic op);
      req_a[i*4 +: 4] = a;
      req_b[i*4 +: 4] = b;
      req_op[i]       = op;
   endtask

   // One full transaction from a single requester, with rsp_ready held high
   task automatic run_op(input string tag, input int i, input logic [3:0] a,
                         input logic [3:0] b, input logic op,
                         input logic [3:0] es, input logic ec, input logic eovf);
      set_req(i, a, b, op);
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      req_valid[i] = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'(req_valid));
      step();
      req_valid = 2'b00;
      chk({tag, "_exec_a"}, 32'(add_a), 32'(a));
      chk({tag, "_exec_b"}, 32'(add_b), 32'(b));
      chk({tag, "_exec_cin_sop"}, 32'({add_cin, add_sop}), 32'({op, op}));
      chk({tag, "_exec_novalid"}, 32'({rsp_valid, req_ready}), 32'd0);
      step();
      chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_sum, rsp_cout}),
          32'({1'b1, 1'(i), es, ec}));
      chk({tag, "_rsp_addzero"}, 32'({add_a, add_b, add_cin, add_sop}), 32'd0);
`ifdef ADDSUB_ARB_OVF_EN
      chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(eovf));
`else
      if (eovf === 1'bx) chk({tag, "_ovf_arg"}, 32'(eovf), 32'd0);
`endif
      step();
      chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;
      #2;
      chk("reset_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
                              add_a, add_b, add_cin, add_sop}), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;

      // Basic add and subtract, plus the borrow and wrap boundaries
      run_op("add0", 0, 4'b0100, 4'b0010, 1'b0, 4'b0110, 1'b0, 1'b0);
      run_op("sub1", 1, 4'b0100, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0);
      run_op("borrow", 0, 4'b0010, 4'b0100, 1'b1, 4'b1110, 1'b0, 1'b0);
      run_op("wrap", 1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);

      // Both requesters valid continuously from reset: strict alternation
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      set_req(0, 4'd1, 4'd1, 1'b0);
      set_req(1, 4'd3, 4'd2, 1'b1);
      req_valid = 2'b11;
      #1;
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("rr_ready%0d", n), 32'(req_ready), (n % 2) ? 32'd2 : 32'd1);
         step();
         step();
         chk($sformatf("rr_rsp%0d", n), 32'({rsp_valid, rsp_id, rsp_sum, rsp_cout}),
             (n % 2) ? 32'({1'b1, 1'b1, 4'd1, 1'b1}) : 32'({1'b1, 1'b0, 4'd2, 1'b0}));
         step();
      end

      // Back-pressure on the response channel while both requests stay held
      set_req(0, 4'd9, 4'd3, 1'b0);
      rsp_ready = 1'b0;
      #1;
      chk("bp_ready", 32'(req_ready), 32'd1);
      step();
      chk("bp_exec_ready", 32'(req_ready), 32'd0);
      step();
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("bp_hold%0d", n),
             32'({rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready}),
             32'({1'b1, 1'b0, 4'd12, 1'b0, 2'b00}));
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_release", 32'({rsp_valid, req_ready}), 32'({1'b0, 2'b10}));

      // Reset in the middle of EXEC aborts the operation, and rr_ptr returns to 0
      set_req(0, 4'd5, 4'd5, 1'b0);
      req_valid = 2'b01;
      #1;
      chk("abort_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      chk("abort_exec_a", 32'(add_a), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
                              add_a, add_b, add_cin, add_sop}), 32'd0);
      step();
      chk("abort_in_rst", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      step();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      step();
      chk("abort_no_rsp2", 32'(rsp_valid), 32'd0);
      req_valid = 2'b11;
      #1;
      chk("abort_ptr0", 32'(req_ready), 32'd1);
      req_valid = 2'b00;
      #1;

`ifdef ADDSUB_ARB_OVF_EN
      run_op("ovf_add", 0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
      run_op("ovf_sub", 0, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
      run_op("noovf",   0, 4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
